// File: rtl/watchdog_reset.sv
// Watchdog timer: a reloadable down-counter armed by enable and refreshed by kick.
// On expiry it holds an active-low reset request for PULSE_LEN cycles.
module watchdog_reset #(
    parameter int TIMEOUT_BITS = 16,
    parameter int PULSE_LEN    = 16,
    parameter int WARN         = 8
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    enable,
    input  logic                    kick,
    input  logic [TIMEOUT_BITS-1:0] timeout,
    output logic                    rst_req_n,
    output logic                    warn,
    output logic [7:0]              expired_cnt,
    output logic [1:0]              state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIRE = 2'd2
    } state_e;

    localparam logic [TIMEOUT_BITS-1:0] WARN_LVL   = TIMEOUT_BITS'(WARN);
    localparam logic [TIMEOUT_BITS-1:0] ONE_CNT    = TIMEOUT_BITS'(1);
    localparam logic [7:0]              PULSE_LOAD = 8'(PULSE_LEN - 1);

    state_e                  state_q, state_d;
    logic [TIMEOUT_BITS-1:0] count_q, count_d;
    logic [7:0]              pulse_q, pulse_d;
    logic [7:0]              exp_q, exp_d;
    logic                    rst_req_n_q, rst_req_n_d;
    logic                    warn_q, warn_d;
    logic [TIMEOUT_BITS-1:0] reload_s;

    // A zero timeout still gives the software one cycle of grace.
    assign reload_s = (timeout == '0) ? ONE_CNT : timeout;

    // Next-state, counter and registered-output computation.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        pulse_d = pulse_q;
        exp_d   = exp_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_RUN;
                    count_d = reload_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (kick) begin
                    count_d = reload_s;
                end else if (count_q != '0) begin
                    count_d = count_q - ONE_CNT;
                end else begin
                    state_d = ST_FIRE;
                    pulse_d = PULSE_LOAD;
                    if (exp_q != 8'hFF) begin
                        exp_d = exp_q + 8'd1;
                    end else begin
                        exp_d = exp_q;
                    end
                end
            end
            ST_FIRE: begin
                if (pulse_q == 8'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    pulse_d = pulse_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are derived from the next state so the flops line up with state_q.
        if (state_d == ST_FIRE) begin
            rst_req_n_d = 1'b0;
        end else begin
            rst_req_n_d = 1'b1;
        end
        if ((state_d == ST_RUN) && (count_d <= WARN_LVL)) begin
            warn_d = 1'b1;
        end else begin
            warn_d = 1'b0;
        end
    end

    // State, counters and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            pulse_q     <= 8'd0;
            exp_q       <= 8'd0;
            rst_req_n_q <= 1'b1;
            warn_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            pulse_q     <= pulse_d;
            exp_q       <= exp_d;
            rst_req_n_q <= rst_req_n_d;
            warn_q      <= warn_d;
        end
    end

    assign rst_req_n   = rst_req_n_q;
    assign warn        = warn_q;
    assign expired_cnt = exp_q;
    assign state       = state_q;

endmodule

// File: tb/tb_watchdog_reset.sv
// Self-checking bench for watchdog_reset: directed scenarios plus randomized
// stimulus compared against a cycle-level behavioural model.
module tb_watchdog_reset;

    localparam int TB = 16;
    localparam int PL = 16;
    localparam int WL = 8;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          enable = 1'b0;
    logic          kick = 1'b0;
    logic [TB-1:0] timeout = '0;
    logic          rst_req_n;
    logic          warn;
    logic [7:0]    expired_cnt;
    logic [1:0]    state;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: mode 0 idle, 1 run, 2 fire; m_count = cycles left before expiry,
    // m_low = reset-request cycles still to go, m_exp = expiries seen (capped).
    int m_mode  = 0;
    int m_count = 0;
    int m_low   = 0;
    int m_exp   = 0;

    watchdog_reset #(.TIMEOUT_BITS(TB), .PULSE_LEN(PL), .WARN(WL)) dut (
        .clk(clk), .resetn(resetn), .enable(enable), .kick(kick), .timeout(timeout),
        .rst_req_n(rst_req_n), .warn(warn), .expired_cnt(expired_cnt), .state(state)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        int t;
        t = (timeout == '0) ? 1 : int'(timeout);
        case (m_mode)
            0: if (enable) begin m_mode = 1; m_count = t; end
            1: begin
                if (!enable) m_mode = 0;
                else if (kick) m_count = t;
                else if (m_count > 0) m_count = m_count - 1;
                else begin
                    m_mode = 2;
                    m_low  = PL;
                    m_exp  = (m_exp + 1 > 255) ? 255 : m_exp + 1;
                end
            end
            default: begin
                m_low = m_low - 1;
                if (m_low == 0) m_mode = 0;
            end
        endcase
    endtask

    // Advance one clock; outputs are observed 1 ns after the edge.
    task automatic tick();
        if (resetn == 1'b0) begin
            m_mode = 0; m_count = 0; m_low = 0; m_exp = 0;
        end else begin
            model_step();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0; enable = 1'b0; kick = 1'b0; timeout = '0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; enable = 1'b1; kick = 1'b1; timeout = 16'd5;
        tick();
        tick();
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
        n_checks++; if (rst_req_n !== 1'b1) begin n_fail++; $display("FAIL reset_rst_req_n: got %b want 1", rst_req_n); end
        n_checks++; if (warn !== 1'b0) begin n_fail++; $display("FAIL reset_warn: got %b want 0", warn); end
        n_checks++; if (expired_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_expired: got %0d want 0", expired_cnt); end
        resetn = 1'b1; enable = 1'b0; kick = 1'b0;
    endtask

    task automatic test_expiry();
        int run = 0, wcnt = 0, wfirst = -1, low = 0, bad = 0;
        do_reset();
        timeout = 16'd10; enable = 1'b1;
        tick();
        for (int c = 0; c < 100 && state == 2'd1; c++) begin
            if (warn === 1'b1) begin wcnt++; if (wfirst < 0) wfirst = run; end
            if (rst_req_n !== 1'b1) bad++;
            run++;
            tick();
        end
        for (int c = 0; c < 100 && state == 2'd2; c++) begin
            if (rst_req_n === 1'b0) low++;
            if (warn !== 1'b0) bad++;
            tick();
        end
        n_checks++; if (run != 11) begin n_fail++; $display("FAIL expiry_run_len: got %0d want 11", run); end
        n_checks++; if (wcnt != 9 || wfirst != 2) begin n_fail++; $display("FAIL expiry_warn: got %0d cycles from %0d want 9 from 2", wcnt, wfirst); end
        n_checks++; if (low != 16) begin n_fail++; $display("FAIL expiry_pulse_len: got %0d want 16", low); end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL expiry_levels: got %0d bad cycles want 0", bad); end
        n_checks++; if (expired_cnt !== 8'd1) begin n_fail++; $display("FAIL expiry_count: got %0d want 1", expired_cnt); end
        n_checks++; if (state !== 2'd0 || rst_req_n !== 1'b1) begin n_fail++; $display("FAIL expiry_post_idle: got state %0d rst %b want 0 1", state, rst_req_n); end
        tick();
        n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL expiry_rearm: got %0d want 1", state); end
    endtask

    task automatic test_kick_periodic();
        int bad_rst = 0, bad_warn = 0;
        do_reset();
        timeout = 16'd10; enable = 1'b1;
        tick();
        for (int i = 0; i < 200; i++) begin
            kick = (i % 5 == 4) ? 1'b1 : 1'b0;
            tick();
            if (rst_req_n !== 1'b1 || state !== 2'd1) bad_rst++;
            if (warn !== ((m_mode == 1 && m_count <= WL) ? 1'b1 : 1'b0)) bad_warn++;
        end
        kick = 1'b0;
        n_checks++; if (bad_rst != 0) begin n_fail++; $display("FAIL kick_no_fire: got %0d bad cycles want 0", bad_rst); end
        n_checks++; if (expired_cnt !== 8'd0) begin n_fail++; $display("FAIL kick_expired: got %0d want 0", expired_cnt); end
        n_checks++; if (bad_warn != 0) begin n_fail++; $display("FAIL kick_warn: got %0d bad cycles want 0", bad_warn); end
    endtask

    task automatic test_kick_at_zero();
        int run = 0;
        do_reset();
        timeout = 16'd10; enable = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) tick();
        n_checks++; if (warn !== 1'b1 || state !== 2'd1) begin n_fail++; $display("FAIL zero_reached: got state %0d warn %b want 1 1", state, warn); end
        kick = 1'b1;
        tick();
        kick = 1'b0;
        n_checks++; if (state !== 2'd1 || rst_req_n !== 1'b1 || warn !== 1'b0) begin n_fail++; $display("FAIL zero_kick: got state %0d rst %b warn %b want 1 1 0", state, rst_req_n, warn); end
        for (int c = 0; c < 100 && state == 2'd1; c++) begin run++; tick(); end
        n_checks++; if (run != 11) begin n_fail++; $display("FAIL zero_kick_reload: got %0d run cycles want 11", run); end

        do_reset();
        timeout = 16'd10; enable = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) tick();
        enable = 1'b0;
        tick();
        tick();
        tick();
        n_checks++; if (state !== 2'd0 || rst_req_n !== 1'b1 || expired_cnt !== 8'd0) begin n_fail++; $display("FAIL zero_disable: got state %0d rst %b exp %0d want 0 1 0", state, rst_req_n, expired_cnt); end
    endtask

    task automatic test_enable_drop_fire();
        int low = 0, bad = 0;
        do_reset();
        timeout = 16'd3; enable = 1'b1;
        for (int c = 0; c < 50 && state != 2'd2; c++) tick();
        for (int c = 0; c < 40 && state == 2'd2; c++) begin
            if (rst_req_n === 1'b0) low++;
            if (low == 3) enable = 1'b0;
            tick();
        end
        n_checks++; if (low != 16) begin n_fail++; $display("FAIL drop_pulse_len: got %0d want 16", low); end
        for (int i = 0; i < 5; i++) begin
            if (state !== 2'd0 || rst_req_n !== 1'b1) bad++;
            tick();
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL drop_stay_idle: got %0d bad cycles want 0", bad); end
    endtask

    task automatic test_timeout_zero_saturate();
        int run = 0, fires = 1;
        logic [1:0] prev;
        do_reset();
        timeout = '0; enable = 1'b1;
        tick();
        for (int c = 0; c < 20 && state == 2'd1; c++) begin run++; tick(); end
        n_checks++; if (run != 2) begin n_fail++; $display("FAIL t0_run_len: got %0d want 2", run); end
        for (int c = 0; c < 6000 && fires < 300; c++) begin
            prev = state;
            tick();
            if (state == 2'd2 && prev != 2'd2) fires++;
        end
        n_checks++; if (fires != 300 || expired_cnt !== 8'd255) begin n_fail++; $display("FAIL t0_saturate: got %0d fires count %0d want 300 255", fires, expired_cnt); end
    endtask

    task automatic test_async_reset_fire();
        do_reset();
        timeout = 16'd2; enable = 1'b1;
        for (int c = 0; c < 50 && state != 2'd2; c++) tick();
        for (int i = 0; i < 4; i++) tick();
        n_checks++; if (rst_req_n !== 1'b0 || expired_cnt !== 8'd1) begin n_fail++; $display("FAIL async_pre: got rst %b exp %0d want 0 1", rst_req_n, expired_cnt); end
        #2;
        resetn = 1'b0;
        #1;
        n_checks++; if (rst_req_n !== 1'b1 || state !== 2'd0 || expired_cnt !== 8'd0 || warn !== 1'b0) begin n_fail++; $display("FAIL async_reset: got rst %b state %0d exp %0d warn %b want 1 0 0 0", rst_req_n, state, expired_cnt, warn); end
        #1;
        resetn = 1'b1;
        tick();
        n_checks++; if (state !== 2'd1) begin n_fail++; $display("FAIL async_resume: got %0d want 1", state); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            enable  = ($urandom % 16 != 0) ? 1'b1 : 1'b0;
            kick    = ($urandom % 8 == 0) ? 1'b1 : 1'b0;
            timeout = TB'($urandom_range(0, 12));
            tick();
            n_checks++; if (state !== 2'(m_mode)) begin n_fail++; $display("FAIL rnd_state[%0d]: got %0d want %0d", i, state, m_mode); end
            n_checks++; if (rst_req_n !== ((m_mode == 2) ? 1'b0 : 1'b1)) begin n_fail++; $display("FAIL rnd_rst_req_n[%0d]: got %b want %b", i, rst_req_n, (m_mode != 2)); end
            n_checks++; if (warn !== ((m_mode == 1 && m_count <= WL) ? 1'b1 : 1'b0)) begin n_fail++; $display("FAIL rnd_warn[%0d]: got %b want %b", i, warn, (m_mode == 1 && m_count <= WL)); end
            n_checks++; if (expired_cnt !== 8'(m_exp)) begin n_fail++; $display("FAIL rnd_expired[%0d]: got %0d want %0d", i, expired_cnt, m_exp); end
        end
    endtask

    initial begin
        test_reset();
        test_expiry();
        test_kick_periodic();
        test_kick_at_zero();
        test_enable_drop_fire();
        test_timeout_zero_saturate();
        test_async_reset_fire();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
